// File: rtl/counter_ctrl.sv
// Front-end controller for an external counter: synchronizes and debounces four
// pushbuttons, turns presses into load / run / direction commands for the counter.
module counter_ctrl #(
   parameter int DEBOUNCE_CYCLES = 100_000
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       btn_load,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_run,
   input  logic [3:0] sw_in,
   input  logic       Tick,
   output logic       Load,
   output logic [3:0] Count_in,
   output logic       Count_en,
   output logic       Up,
   output logic       o_state_dbg
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Button index map: 0 load, 1 up, 2 down, 3 run
   localparam int B_LOAD = 0;
   localparam int B_UP   = 1;
   localparam int B_DOWN = 2;
   localparam int B_RUN  = 3;

   typedef enum logic {
      S_IDLE      = 1'b0,
      S_LOAD_PEND = 1'b1
   } state_t;

   logic [3:0] w_btn_raw;
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] w_press;
   logic       r_tick_s1;
   logic       r_tick_s2;
   logic       r_tick_q;
   logic       w_tick_fall;
   state_t     r_state;
   logic       r_load;
   logic [3:0] r_count_in;
   logic       r_count_en;
   logic       r_up;

   assign w_btn_raw = {btn_run, btn_down, btn_up, btn_load};

   always_ff @(posedge Clk or posedge nReset) begin
      if (nReset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_tick_s1 <= 1'b0;
         r_tick_s2 <= 1'b0;
         r_tick_q  <= 1'b0;
      end else begin
         r_sync1   <= w_btn_raw;
         r_sync2   <= r_sync1;
         r_tick_s1 <= Tick;
         r_tick_s2 <= r_tick_s1;
         r_tick_q  <= r_tick_s2;
      end
   end

   assign w_tick_fall = r_tick_q & ~r_tick_s2;

   // The counter only runs while the synced level disagrees with the accepted level,
   // so any bounce back to the accepted level restarts the stability window.
   for (genvar g = 0; g < 4; g++) begin : g_db
      logic          r_db;
      logic [CW-1:0] r_cnt;
      logic          r_press;

      always_ff @(posedge Clk or posedge nReset) begin
         if (nReset) begin
            r_db    <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
         end else begin
            r_press <= 1'b0;
            if (r_sync2[g] == r_db) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_db    <= r_sync2[g];
               r_cnt   <= '0;
               r_press <= r_sync2[g];
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end

      assign w_press[g] = r_press;
   end

   always_ff @(posedge Clk or posedge nReset) begin
      if (nReset) begin
         r_state    <= S_IDLE;
         r_load     <= 1'b0;
         r_count_in <= 4'h0;
         r_count_en <= 1'b0;
         r_up       <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_press[B_LOAD]) begin
                  r_count_in <= sw_in;
                  r_load     <= 1'b1;
                  r_state    <= S_LOAD_PEND;
               end
            end
            S_LOAD_PEND: begin
               // Hold the request until the counter has seen one Tick fall.
               if (w_tick_fall) begin
                  r_load  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_load  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase

         if (w_press[B_RUN]) begin
            r_count_en <= ~r_count_en;
         end

         if (w_press[B_UP] && !w_press[B_DOWN]) begin
            r_up <= 1'b1;
         end else if (w_press[B_DOWN] && !w_press[B_UP]) begin
            r_up <= 1'b0;
         end
      end
   end

   assign Load        = r_load;
   assign Count_in    = r_count_in;
   assign Count_en    = r_count_en;
   assign Up          = r_up;
   assign o_state_dbg = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with DEBOUNCE_CYCLES=4: directed scenarios plus a random
// run compared every cycle against a window-based behavioural model.
module tb_counter_ctrl;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic [3:0] sw;
   logic       tick;
   logic       load;
   logic [3:0] count_in;
   logic       count_en;
   logic       up;
   logic       state_dbg;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   counter_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
      .Clk         (clk),
      .nReset      (rst),
      .btn_load    (btn[0]),
      .btn_up      (btn[1]),
      .btn_down    (btn[2]),
      .btn_run     (btn[3]),
      .sw_in       (sw),
      .Tick        (tick),
      .Load        (load),
      .Count_in    (count_in),
      .Count_en    (count_en),
      .Up          (up),
      .o_state_dbg (state_dbg)
   );

   // Reference model: a button level is accepted once its last DC synced samples
   // all disagree with the accepted level; a press acts one edge later.
   logic          m_load;
   logic [3:0]    m_cnt_in;
   logic          m_en;
   logic          m_up;
   bit   [3:0]    m_db;
   bit   [3:0]    m_press;
   bit   [1:0]    m_dly [4];
   bit   [DC-1:0] m_win [4];
   int            m_fill [4];
   bit   [2:0]    m_th;

   always @(posedge clk or posedge rst) begin : model
      bit fall;
      bit seen;
      if (rst) begin
         m_load   = 1'b0;
         m_cnt_in = 4'h0;
         m_en     = 1'b0;
         m_up     = 1'b1;
         m_db     = '0;
         m_press  = '0;
         m_th     = '0;
         for (int b = 0; b < 4; b++) begin
            m_dly[b]  = '0;
            m_win[b]  = '0;
            m_fill[b] = 0;
         end
      end else begin
         fall = m_th[2] & ~m_th[1];
         m_th = {m_th[1:0], tick};
         if (m_load) begin
            if (fall) m_load = 1'b0;
         end else if (m_press[0]) begin
            m_load   = 1'b1;
            m_cnt_in = sw;
         end
         if (m_press[3]) m_en = !m_en;
         if (m_press[1] && !m_press[2]) m_up = 1'b1;
         else if (m_press[2] && !m_press[1]) m_up = 1'b0;
         for (int b = 0; b < 4; b++) begin
            seen      = m_dly[b][1];
            m_dly[b]  = {m_dly[b][0], btn[b]};
            m_win[b]  = {m_win[b][DC-2:0], seen};
            m_fill[b] = m_fill[b] + 1;
            m_press[b] = 1'b0;
            if (m_fill[b] >= DC && m_win[b] == (m_db[b] ? {DC{1'b0}} : {DC{1'b1}})) begin
               m_db[b]    = seen;
               m_press[b] = seen;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      btn  = '0;
      sw   = 4'h0;
      tick = 1'b0;
      cyc(3);
      total_cnt++;
      if ({load, count_en, up, count_in, state_dbg} !== {1'b0, 1'b0, 1'b1, 4'h0, 1'b0})
         $display("FAIL reset_hold: got load=%b en=%b up=%b cin=%h st=%b, expected 0 0 1 0 0",
                  load, count_en, up, count_in, state_dbg);
      else pass_cnt++;
      rst = 1'b0;
      cyc(3);
      total_cnt++;
      if ({load, count_en, up, count_in} !== {1'b0, 1'b0, 1'b1, 4'h0})
         $display("FAIL reset_release: got load=%b en=%b up=%b cin=%h, expected 0 0 1 0",
                  load, count_en, up, count_in);
      else pass_cnt++;
   endtask

   task automatic test_load();
      tick = 1'b1;
      cyc(4);
      sw     = 4'hA;
      btn[0] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         if (k == 6) begin
            total_cnt++;
            if (load !== 1'b0) $display("FAIL load_early: got %b expected 0", load);
            else pass_cnt++;
         end
         if (k == 7) begin
            total_cnt++;
            if ({load, count_in} !== {1'b1, 4'hA})
               $display("FAIL load_latency: got load=%b cin=%h expected 1 a", load, count_in);
            else pass_cnt++;
         end
      end
      btn[0] = 1'b0;
      cyc(5);
      total_cnt++;
      if ({load, state_dbg} !== 2'b11) $display("FAIL load_hold: got load=%b st=%b expected 1 1", load, state_dbg);
      else pass_cnt++;
      tick = 1'b0;
      cyc(2);
      total_cnt++;
      if (load !== 1'b1) $display("FAIL load_drop_early: got %b expected 1", load);
      else pass_cnt++;
      cyc(1);
      total_cnt++;
      if ({load, state_dbg} !== 2'b00) $display("FAIL load_drop: got load=%b st=%b expected 0 0", load, state_dbg);
      else pass_cnt++;
      tick = 1'b1;
      cyc(3);
      tick = 1'b0;
      cyc(4);
      total_cnt++;
      if ({load, count_in} !== {1'b0, 4'hA})
         $display("FAIL load_single_fall: got load=%b cin=%h expected 0 a", load, count_in);
      else pass_cnt++;
   endtask

   task automatic test_run_bounce();
      int   toggles = 0;
      logic prev    = count_en;
      for (int i = 0; i < 28; i++) begin
         if (i < 8) btn[3] = (i % 2 == 0);
         else if (i < 18) btn[3] = 1'b1;
         else btn[3] = 1'b0;
         cyc(1);
         if (count_en !== prev) toggles++;
         prev = count_en;
      end
      total_cnt++;
      if (toggles !== 1 || count_en !== 1'b1)
         $display("FAIL run_bounce: got toggles=%0d en=%b expected 1 1", toggles, count_en);
      else pass_cnt++;
      btn[3] = 1'b1;
      cyc(10);
      btn[3] = 1'b0;
      cyc(10);
      total_cnt++;
      if (count_en !== 1'b0) $display("FAIL run_second: got %b expected 0", count_en);
      else pass_cnt++;
   endtask

   task automatic test_updown();
      btn[2] = 1'b1;
      cyc(10);
      btn[2] = 1'b0;
      cyc(10);
      total_cnt++;
      if (up !== 1'b0) $display("FAIL down_press: got %b expected 0", up);
      else pass_cnt++;
      btn[2:1] = 2'b11;
      cyc(10);
      btn[2:1] = 2'b00;
      cyc(10);
      total_cnt++;
      if (up !== 1'b0) $display("FAIL up_down_same: got %b expected 0", up);
      else pass_cnt++;
      btn[1] = 1'b1;
      cyc(10);
      btn[1] = 1'b0;
      cyc(10);
      total_cnt++;
      if (up !== 1'b1) $display("FAIL up_press: got %b expected 1", up);
      else pass_cnt++;
   endtask

   task automatic test_load_ignored();
      int   rises = 0;
      logic prev;
      rst = 1'b1;
      cyc(1);
      rst  = 1'b0;
      tick = 1'b1;
      cyc(4);
      prev = load;
      for (int i = 0; i < 45; i++) begin
         sw     = (i < 16) ? 4'hA : 4'h3;
         btn[0] = (i < 8) || (i >= 16 && i < 24);
         if (i == 32) tick = 1'b0;
         if (i == 31) begin
            total_cnt++;
            if ({load, count_in} !== {1'b1, 4'hA})
               $display("FAIL load_ignore_pend: got load=%b cin=%h expected 1 a", load, count_in);
            else pass_cnt++;
         end
         cyc(1);
         if (load === 1'b1 && prev !== 1'b1) rises++;
         prev = load;
      end
      total_cnt++;
      if (rises !== 1 || load !== 1'b0 || count_in !== 4'hA)
         $display("FAIL load_ignore_once: got rises=%0d load=%b cin=%h expected 1 0 a", rises, load, count_in);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      tick = 1'b1;
      cyc(4);
      sw     = 4'h5;
      btn[0] = 1'b1;
      cyc(8);
      btn[0] = 1'b0;
      total_cnt++;
      if ({load, count_in} !== {1'b1, 4'h5})
         $display("FAIL reset_mid_pend: got load=%b cin=%h expected 1 5", load, count_in);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (load !== 1'b0) $display("FAIL reset_mid_async: got %b expected 0", load);
      else pass_cnt++;
      cyc(2);
      rst = 1'b0;
      cyc(2);
      total_cnt++;
      if ({load, state_dbg, count_in} !== {1'b0, 1'b0, 4'h0})
         $display("FAIL reset_mid_after: got load=%b st=%b cin=%h expected 0 0 0", load, state_dbg, count_in);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int hold [4];
      int tick_hold = 0;
      for (int b = 0; b < 4; b++) hold[b] = 0;
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < 4; b++) begin
            if (hold[b] == 0) begin
               btn[b]  = 1'($urandom_range(0, 1));
               hold[b] = $urandom_range(1, 10);
            end
            hold[b]--;
         end
         if (tick_hold == 0) begin
            tick      = ~tick;
            tick_hold = $urandom_range(1, 12);
         end
         tick_hold--;
         sw = 4'($urandom_range(0, 15));
         cyc(1);
         total_cnt++;
         if ({load, count_in, count_en, up} !== {m_load, m_cnt_in, m_en, m_up})
            $display("FAIL random_cycle_%0d: got load=%b cin=%h en=%b up=%b expected %b %h %b %b",
                     n, load, count_in, count_en, up, m_load, m_cnt_in, m_en, m_up);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_run_bounce();
      test_updown();
      test_load_ignored();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100_000, consecutive stable Clk cycles needed to accept a button level change (10 ms at 10 MHz).
REQ-002 SHALL use reset nReset, asynchronous, active-high; clock Clk.
REQ-003 SHALL have port Clk  input  1  system clock (10 MHz), all logic on rising edge.
REQ-004 SHALL have port nReset  input  1  asynchronous reset, active-high.
REQ-005 SHALL have ports btn_load, btn_up, btn_down, btn_run  input  1 each  raw asynchronous pushbuttons, 1 = pressed.
REQ-006 SHALL have port sw_in  input  4  raw asynchronous preset switches.
REQ-007 SHALL have port Tick  input  1  divided clock from counter; counter samples its controls on Tick falling edge.
REQ-008 SHALL have port Load  output  1  load request to counter.
REQ-009 SHALL have port Count_in  output  4  preset value to counter.
REQ-010 SHALL have port Count_en  output  1  count enable to counter.
REQ-011 SHALL have port Up  output  1  direction to counter, 1 = up.

Function
REQ-012 SHALL pass each button and Tick through a 2-flop synchronizer; sw_in captured only on a load event (no synchronizer).
REQ-013 SHALL keep per button a debounced level db and counter of width $clog2(DEBOUNCE_CYCLES+1); counter cleared whenever synced level equals db.
REQ-014 SHALL, when synced level differs from db and counter equals DEBOUNCE_CYCLES-1, set db to synced level and clear counter; otherwise increment counter.
REQ-015 SHALL generate a one-cycle press event on db 0->1 only; releases generate nothing.
REQ-016 SHALL react to a press event on the next Clk edge: output changes DEBOUNCE_CYCLES+2 edges after the edge first sampling raw high.
REQ-017 SHALL implement FSM IDLE / LOAD_PEND; IDLE: Load=0; LOAD_PEND: Load=1.
REQ-018 SHALL, in IDLE on load event, latch sw_in into Count_in, assert Load, enter LOAD_PEND.
REQ-019 SHALL, in LOAD_PEND, detect falling edge of synchronized Tick (registered 1 then current 0), then deassert Load and return to IDLE on the same edge.
REQ-020 SHALL hold Count_in stable during LOAD_PEND; load events in LOAD_PEND ignored.
REQ-021 SHALL toggle Count_en on each run event, in either FSM state.
REQ-022 SHALL set Up=1 on up event, Up=0 on down event; simultaneous up and down events leave Up unchanged.
REQ-023 SHALL process load, run and up/down events arriving in the same cycle independently and simultaneously.
REQ-024 SHALL not assert Load for more than one Tick falling edge per load event.
REQ-025 SHALL keep Tick held constant with Load pending (no timeout) in LOAD_PEND indefinitely.

Reset
REQ-026 SHALL, while nReset=1, force Load=0, Count_en=0, Up=1, Count_in=4'h0, FSM=IDLE, all db=0, debounce counters=0, synchronizer and Tick-history flops=0.
REQ-027 SHALL, on reset asserted mid-LOAD_PEND, drop Load immediately (asynchronously) and return to IDLE.
REQ-028 SHALL, after reset release with a button held, treat the held button as a new press once debounced.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 SHALL cover: reset pulse -> Load=0, Count_en=0, Up=1, Count_in=0.
REQ-030 SHALL cover: sw_in=4'hA, btn_load held 10 cycles -> Load=1, Count_in=4'hA 6 edges after first sample; Tick 1->0 -> Load=0 within 3 edges; Load=1 never spans two Tick falls.
REQ-031 SHALL cover: btn_run bouncing 1,0,1,0 every cycle then stable 1 -> exactly one Count_en toggle 0->1; second clean press -> 0.
REQ-032 SHALL cover: btn_down press -> Up=0; btn_up and btn_down pressed same cycle -> Up stays 0.
REQ-033 SHALL cover: second btn_load with sw_in=4'h3 during LOAD_PEND -> Count_in stays 4'hA, one Load pulse only.
REQ-034 SHALL cover: nReset asserted during LOAD_PEND -> Load=0 same cycle, IDLE after release, Count_in=0.
